// File: rtl/multicycle_controller_if.sv
// Instruction fields, status inputs and control outputs between the
// multicycle datapath (master) and its controller (slave).
interface multicycle_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic       zero;
   logic       mem_ready;
   logic       pc_write;
   logic       adr_src;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       illegal_op;
   logic [1:0] result_src;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] imm_src;
   logic [2:0] alu_control;
   logic [3:0] state_o;

   modport master (
      output op, funct3, funct7, zero, mem_ready,
      input  pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
      input  result_src, alu_src_a, alu_src_b, imm_src, alu_control, state_o
   );

   modport slave (
      input  op, funct3, funct7, zero, mem_ready,
      output pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op,
      output result_src, alu_src_a, alu_src_b, imm_src, alu_control, state_o
   );
endinterface

// File: rtl/multicycle_controller.sv
// Moore-style control FSM for a multicycle RV32 subset datapath. Write strobes
// are gated low while rst_n is held so nothing is committed during reset.
module multicycle_controller (
   input  logic                   clk,
   input  logic                   rst_n,
   multicycle_controller_if.slave ctrl
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_EXECI    = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9,
      S_JAL      = 4'd10,
      S_JALR     = 4'd11,
      S_JALRPC   = 4'd12,
      S_LUI      = 4'd13
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_B     = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] SA_PC    = 2'b00;
   localparam logic [1:0] SA_OLDPC = 2'b01;
   localparam logic [1:0] SA_RS1   = 2'b10;
   localparam logic [1:0] SA_ZERO  = 2'b11;
   localparam logic [1:0] SB_RS2   = 2'b00;
   localparam logic [1:0] SB_IMM   = 2'b01;
   localparam logic [1:0] SB_FOUR  = 2'b10;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_MEM    = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;

   function automatic logic [2:0] alu_r_dec(input logic [2:0] f3, input logic [6:0] f7);
      logic [2:0] code;
      case ({f3, f7})
         {3'b000, 7'h00}: code = ALU_ADD;
         {3'b000, 7'h20}: code = ALU_SUB;
         {3'b110, 7'h00}: code = ALU_OR;
         {3'b111, 7'h00}: code = ALU_AND;
         {3'b010, 7'h00}: code = ALU_SLT;
         default:         code = ALU_ADD;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] alu_i_dec(input logic [2:0] f3);
      logic [2:0] code;
      case (f3)
         3'b000:  code = ALU_ADD;
         3'b110:  code = ALU_OR;
         3'b010:  code = ALU_SLT;
         3'b111:  code = ALU_AND;
         default: code = ALU_ADD;
      endcase
      return code;
   endfunction

   function automatic logic [2:0] imm_dec(input logic [6:0] opc);
      logic [2:0] sel;
      case (opc)
         OP_STORE:         sel = 3'b001;
         OP_B:             sel = 3'b010;
         OP_JAL:           sel = 3'b011;
         OP_LUI, OP_AUIPC: sel = 3'b100;
         default:          sel = 3'b000;
      endcase
      return sel;
   endfunction

   state_t     state_r;
   state_t     next_s;
   logic       pc_w_s, ir_w_s, reg_w_s, mem_w_s, ill_s, adr_s;
   logic [1:0] res_s, sa_s, sb_s;
   logic [2:0] alu_s;

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r <= S_FETCH;
      end else begin
         state_r <= next_s;
      end
   end

   // Next-state and per-state control decode; unlisted outputs stay 0.
   always_comb begin
      next_s  = state_r;
      pc_w_s  = 1'b0;
      ir_w_s  = 1'b0;
      reg_w_s = 1'b0;
      mem_w_s = 1'b0;
      ill_s   = 1'b0;
      adr_s   = 1'b0;
      res_s   = RES_ALUOUT;
      sa_s    = SA_PC;
      sb_s    = SB_RS2;
      alu_s   = ALU_ADD;
      case (state_r)
         S_FETCH: begin
            sb_s  = SB_FOUR;
            res_s = RES_ALURES;
            if (ctrl.mem_ready) begin
               ir_w_s = 1'b1;
               pc_w_s = 1'b1;
               next_s = S_DECODE;
            end else begin
               next_s = S_FETCH;
            end
         end
         S_DECODE: begin
            sa_s = SA_OLDPC;
            sb_s = SB_IMM;
            case (ctrl.op)
               OP_LOAD, OP_STORE: next_s = S_MEMADR;
               OP_R:              next_s = S_EXECR;
               OP_I:              next_s = S_EXECI;
               OP_B:              next_s = S_BRANCH;
               OP_JAL:            next_s = S_JAL;
               OP_JALR:           next_s = S_JALR;
               OP_LUI:            next_s = S_LUI;
               default: begin
                  next_s = S_FETCH;
                  ill_s  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            sa_s   = SA_RS1;
            sb_s   = SB_IMM;
            next_s = (ctrl.op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            adr_s  = 1'b1;
            next_s = ctrl.mem_ready ? S_MEMWB : S_MEMREAD;
         end
         S_MEMWB: begin
            res_s   = RES_MEM;
            reg_w_s = 1'b1;
            next_s  = S_FETCH;
         end
         S_MEMWRITE: begin
            adr_s   = 1'b1;
            mem_w_s = 1'b1;
            next_s  = ctrl.mem_ready ? S_FETCH : S_MEMWRITE;
         end
         S_EXECR: begin
            sa_s   = SA_RS1;
            alu_s  = alu_r_dec(ctrl.funct3, ctrl.funct7);
            next_s = S_ALUWB;
         end
         S_EXECI: begin
            sa_s   = SA_RS1;
            sb_s   = SB_IMM;
            alu_s  = alu_i_dec(ctrl.funct3);
            next_s = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w_s = 1'b1;
            next_s  = S_FETCH;
         end
         S_BRANCH: begin
            sa_s   = SA_RS1;
            alu_s  = ALU_SUB;
            pc_w_s = ((ctrl.funct3 == 3'b000) &&  ctrl.zero) ||
                     ((ctrl.funct3 == 3'b001) && !ctrl.zero);
            next_s = S_FETCH;
         end
         S_JAL, S_JALRPC: begin
            sa_s   = SA_OLDPC;
            sb_s   = SB_FOUR;
            pc_w_s = 1'b1;
            next_s = S_ALUWB;
         end
         S_JALR: begin
            sa_s   = SA_RS1;
            sb_s   = SB_IMM;
            next_s = S_JALRPC;
         end
         S_LUI: begin
            sa_s   = SA_ZERO;
            sb_s   = SB_IMM;
            next_s = S_ALUWB;
         end
         default: begin
            next_s = S_FETCH;
         end
      endcase
   end

   assign ctrl.pc_write    = pc_w_s & rst_n;
   assign ctrl.ir_write    = ir_w_s & rst_n;
   assign ctrl.mem_write   = mem_w_s & rst_n;
   assign ctrl.reg_write   = reg_w_s & rst_n;
   assign ctrl.illegal_op  = ill_s & rst_n;
   assign ctrl.adr_src     = adr_s;
   assign ctrl.result_src  = res_s;
   assign ctrl.alu_src_a   = sa_s;
   assign ctrl.alu_src_b   = sb_s;
   assign ctrl.alu_control = alu_s;
   assign ctrl.imm_src     = imm_dec(ctrl.op);
   assign ctrl.state_o     = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench: builds the expected per-cycle control trace of each instruction from
// the instruction-level rules, then steps the controller and compares.
module tb_multicycle_controller;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multicycle_controller_if bus();
   multicycle_controller dut (.clk(clk), .rst_n(rst_n), .ctrl(bus));

   localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
   localparam logic [6:0] BR = 7'b1100011, JL = 7'b1101111, JR = 7'b1100111, LU = 7'b0110111;
   // strobe vector order: pc_write, ir_write, reg_write, mem_write, illegal_op, adr_src
   localparam logic [5:0] W_NONE = 6'b000000, W_PC = 6'b100000, W_IR = 6'b010000, W_REG = 6'b001000;
   localparam logic [5:0] W_MEM = 6'b000100, W_ILL = 6'b000010, W_ADR = 6'b000001;

   typedef struct {
      logic [3:0] st;
      logic       mr;
      logic [5:0] strb;
      logic [1:0] res;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [2:0] ctl;
   } step_t;

   step_t exp_q[$];
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic add(input logic [3:0] st, input logic mr, input logic [5:0] strb,
                      input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                      input logic [2:0] ctl);
      step_t s;
      s.st = st; s.mr = mr; s.strb = strb; s.res = res; s.sa = sa; s.sb = sb; s.ctl = ctl;
      exp_q.push_back(s);
   endtask

   function automatic logic [2:0] imm_ref(input logic [6:0] op);
      if (op == SW) return 3'd1;
      else if (op == BR) return 3'd2;
      else if (op == JL) return 3'd3;
      else if (op == LU || op == 7'b0010111) return 3'd4;
      else return 3'd0;
   endfunction

   function automatic logic [2:0] r_ref(input logic [2:0] f3, input logic [6:0] f7);
      if (f7 == 7'h20) return (f3 == 3'b000) ? 3'b001 : 3'b000;
      if (f7 != 7'h00) return 3'b000;
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      if (f3 == 3'b010) return 3'b101;
      return 3'b000;
   endfunction

   function automatic logic [2:0] i_ref(input logic [2:0] f3);
      if (f3 == 3'b110) return 3'b011;
      if (f3 == 3'b111) return 3'b010;
      if (f3 == 3'b010) return 3'b101;
      return 3'b000;
   endfunction

   // Expected trace of one instruction: fw fetch stalls, mw memory stalls.
   task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic z, input int fw, input int mw);
      logic legal;
      bus.op = op; bus.funct3 = f3; bus.funct7 = f7; bus.zero = z;
      legal = (op inside {LW, SW, RT, IT, BR, JL, JR, LU});
      for (int i = 0; i < fw; i++) add(4'd0, 1'b0, W_NONE, 2'd2, 2'd0, 2'd2, 3'd0);
      add(4'd0, 1'b1, W_PC | W_IR, 2'd2, 2'd0, 2'd2, 3'd0);
      add(4'd1, rnd(), legal ? W_NONE : W_ILL, 2'd0, 2'd1, 2'd1, 3'd0);
      if (op == LW || op == SW) add(4'd2, rnd(), W_NONE, 2'd0, 2'd2, 2'd1, 3'd0);
      if (op == LW) begin
         for (int i = 0; i < mw; i++) add(4'd3, 1'b0, W_ADR, 2'd0, 2'd0, 2'd0, 3'd0);
         add(4'd3, 1'b1, W_ADR, 2'd0, 2'd0, 2'd0, 3'd0);
         add(4'd4, rnd(), W_REG, 2'd1, 2'd0, 2'd0, 3'd0);
      end else if (op == SW) begin
         for (int i = 0; i < mw; i++) add(4'd5, 1'b0, W_MEM | W_ADR, 2'd0, 2'd0, 2'd0, 3'd0);
         add(4'd5, 1'b1, W_MEM | W_ADR, 2'd0, 2'd0, 2'd0, 3'd0);
      end else if (op == RT || op == IT) begin
         if (op == RT) add(4'd6, rnd(), W_NONE, 2'd0, 2'd2, 2'd0, r_ref(f3, f7));
         else          add(4'd7, rnd(), W_NONE, 2'd0, 2'd2, 2'd1, i_ref(f3));
         add(4'd8, rnd(), W_REG, 2'd0, 2'd0, 2'd0, 3'd0);
      end else if (op == BR) begin
         add(4'd9, rnd(), ((f3 == 3'b000 && z) || (f3 == 3'b001 && !z)) ? W_PC : W_NONE,
             2'd0, 2'd2, 2'd0, 3'd1);
      end else if (op == JL || op == JR || op == LU) begin
         if (op == JL) add(4'd10, rnd(), W_PC, 2'd0, 2'd1, 2'd2, 3'd0);
         if (op == JR) begin
            add(4'd11, rnd(), W_NONE, 2'd0, 2'd2, 2'd1, 3'd0);
            add(4'd12, rnd(), W_PC, 2'd0, 2'd1, 2'd2, 3'd0);
         end
         if (op == LU) add(4'd13, rnd(), W_NONE, 2'd0, 2'd3, 2'd1, 3'd0);
         add(4'd8, rnd(), W_REG, 2'd0, 2'd0, 2'd0, 3'd0);
      end
   endtask

   task automatic check_step(input step_t s);
      logic [2:0] nwr;
      chk("state_o", 8'(bus.state_o), 8'(s.st));
      chk("strobes", 8'({bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write,
                         bus.illegal_op, bus.adr_src}), 8'(s.strb));
      chk("mux_sel", 8'({bus.result_src, bus.alu_src_a, bus.alu_src_b}), 8'({s.res, s.sa, s.sb}));
      chk("alu_control", 8'(bus.alu_control), 8'(s.ctl));
      chk("imm_src", 8'(bus.imm_src), 8'(imm_ref(bus.op)));
      nwr = 3'(bus.reg_write) + 3'(bus.mem_write) + 3'(bus.ir_write);
      chk("one_write", 8'(nwr <= 3'd1), 8'd1);
   endtask

   task automatic run_q();
      step_t s;
      while (exp_q.size() > 0) begin
         s = exp_q.pop_front();
         bus.mem_ready = s.mr;
         #1;
         check_step(s);
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [6:0] rop;
      logic [6:0] rf7;
      int         pick;
      rst_n = 1'b0;
      bus.op = JL; bus.funct3 = 3'b000; bus.funct7 = 7'h00; bus.zero = 1'b0; bus.mem_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_state", 8'(bus.state_o), 8'd0);
      chk("rst_strobes", 8'({bus.pc_write, bus.ir_write, bus.mem_write, bus.reg_write,
                             bus.illegal_op}), 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      build(RT, 3'b000, 7'h20, 1'b0, 0, 0);      run_q();
      build(LW, 3'b010, 7'h00, 1'b0, 0, 3);      run_q();
      build(BR, 3'b001, 7'h00, 1'b0, 1, 0);      run_q();
      build(BR, 3'b001, 7'h00, 1'b1, 0, 0);      run_q();
      build(BR, 3'b000, 7'h00, 1'b1, 0, 0);      run_q();
      build(JR, 3'b000, 7'h00, 1'b0, 0, 0);      run_q();
      build(7'b1111111, 3'b000, 7'h00, 1'b0, 0, 0); run_q();
      build(SW, 3'b010, 7'h00, 1'b0, 2, 2);      run_q();
      build(IT, 3'b110, 7'h00, 1'b0, 0, 0);      run_q();
      build(JL, 3'b000, 7'h00, 1'b0, 0, 0);      run_q();
      build(LU, 3'b000, 7'h00, 1'b0, 0, 0);      run_q();

      // Stall a store in MEMWRITE, then reset it mid-access.
      build(SW, 3'b010, 7'h00, 1'b0, 0, 1);
      void'(exp_q.pop_back());
      run_q();
      rst_n = 1'b0;
      bus.mem_ready = 1'b0;
      #1;
      chk("midrst_state_before", 8'(bus.state_o), 8'd5);
      chk("midrst_mem_write", 8'(bus.mem_write), 8'd0);
      @(posedge clk);
      #1;
      chk("midrst_state_after", 8'(bus.state_o), 8'd0);
      rst_n = 1'b1;

      for (int n = 0; n < 60; n++) begin
         pick = $urandom_range(0, 8);
         case (pick)
            0: rop = LW;  1: rop = SW;  2: rop = RT;  3: rop = IT;
            4: rop = BR;  5: rop = JL;  6: rop = JR;  7: rop = LU;
            default: rop = 7'($urandom_range(0, 127));
         endcase
         pick = $urandom_range(0, 2);
         rf7 = (pick == 0) ? 7'h00 : (pick == 1) ? 7'h20 : 7'($urandom_range(0, 127));
         build(rop, 3'($urandom_range(0, 7)), rf7, rnd(), $urandom_range(0, 2), $urandom_range(0, 3));
         run_q();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have inputs op[6:0], funct3[2:0], funct7[6:0]: fields of the instruction register.
REQ-004 SHALL have inputs zero (1 bit: ALU result zero) and mem_ready (1 bit: memory access completes this cycle).
REQ-005 SHALL have 1-bit outputs pc_write, adr_src, mem_write, ir_write, reg_write and illegal_op.
REQ-006 SHALL have outputs result_src[1:0], alu_src_a[1:0], alu_src_b[1:0], imm_src[2:0], alu_control[2:0] and state_o[3:0].
REQ-007 SHALL use these mux codes:
- alu_src_a: 00 PC, 01 OldPC, 10 rs1 reg, 11 zero.
- alu_src_b: 00 rs2 reg, 01 imm, 10 const 4.
- result_src: 00 ALUOut, 01 MemData, 10 ALU result.

Function
REQ-008 SHALL implement a Moore FSM with these states and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, JAL 10, JALR 11, JALRPC 12, LUI 13; state_o SHALL equal the current state encoding.
REQ-009 SHALL sequence FETCH as follows:
- Drive adr_src=0, alu_src_a=00, alu_src_b=10, add, result_src=10.
- Assert ir_write=1 and pc_write=1 only in a cycle with mem_ready=1, then go to DECODE.
- Otherwise stay in FETCH.
REQ-010 SHALL sequence DECODE as follows:
- Drive alu_src_a=01, alu_src_b=01, add.
- Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECR; 0010011 -> EXECI; 1100011 -> BRANCH; 1101111 -> JAL; 1100111 -> JALR; 0110111 -> LUI.
- Any other op -> FETCH, with illegal_op=1 for that DECODE cycle only.
REQ-011 SHALL drive alu_src_a=10, alu_src_b=01, add in MEMADR; next state MEMREAD if op=0000011, else MEMWRITE.
REQ-012 SHALL drive result_src=00, adr_src=1 in MEMREAD; stay until mem_ready=1, then go to MEMWB.
REQ-013 SHALL drive result_src=01, reg_write=1 in MEMWB; next state FETCH.
REQ-014 SHALL drive result_src=00, adr_src=1, mem_write=1 in MEMWRITE; mem_write SHALL stay high while waiting; on mem_ready=1 go to FETCH.
REQ-015 SHALL drive alu_src_a=10, alu_src_b=00 in EXECR, and alu_src_a=10, alu_src_b=01 in EXECI; both go to ALUWB.
REQ-016 SHALL drive result_src=00, reg_write=1 in ALUWB; next state FETCH.
REQ-017 SHALL sequence BRANCH as follows:
- Drive alu_src_a=10, alu_src_b=00, sub, result_src=00.
- Drive pc_write = (funct3=000 & zero) | (funct3=001 & ~zero); other funct3 values give pc_write=0.
- Next state FETCH.
REQ-018 SHALL drive alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 in JAL; next state ALUWB.
REQ-019 SHALL drive alu_src_a=10, alu_src_b=01, add in JALR (target into ALUOut); next state JALRPC.
REQ-020 SHALL drive alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 in JALRPC; next state ALUWB.
REQ-021 SHALL drive alu_src_a=11, alu_src_b=01, add in LUI; next state ALUWB.
REQ-022 SHALL use ALU codes add 000, sub 001, and 010, or 011, slt 101.
REQ-023 SHALL decode alu_control in EXECR from funct3/funct7:
- 000/00 add; 000/20 sub; 110/00 or; 111/00 and; 010/00 slt.
- Unsupported combinations give 000.
REQ-024 SHALL decode alu_control in EXECI from funct3: 000 add, 110 or, 010 slt, 111 and; all other funct3 values give 000.
REQ-025 SHALL derive imm_src combinationally from op in every state: I-type, LW and JALR 000; S 001; B 010; J 011; U 100; all other op values 000.
REQ-026 SHALL drive every output not listed for a state as 0 (alu_control 000).
REQ-027 SHALL never assert more than one of reg_write, mem_write and ir_write in the same cycle.

Reset
REQ-028 SHALL load state FETCH on any rising edge with rst_n=0, including mid-instruction (e.g. in MEMWRITE with mem_ready=0).
REQ-029 SHALL force pc_write, ir_write, mem_write, reg_write and illegal_op to 0 while rst_n=0, regardless of state and mem_ready.
REQ-030 SHALL, in the first cycle after rst_n returns to 1, be in FETCH with state_o=0.

Verification
REQ-031 SHALL be verified for R-type: op=0110011, funct3=000, funct7=20, mem_ready=1 -> states 0,1,6,8,0; alu_control=001 in EXECR; reg_write=1 only in ALUWB.
REQ-032 SHALL be verified for LW with wait: op=0000011, mem_ready low 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0; reg_write=1 with result_src=01 only in MEMWB.
REQ-033 SHALL be verified for BNE: op=1100011, funct3=001, zero=0 -> pc_write=1 in BRANCH; repeat with zero=1 -> pc_write=0.
REQ-034 SHALL be verified for JALR: op=1100111 -> states 0,1,11,12,8,0; pc_write=1 only in FETCH and JALRPC.
REQ-035 SHALL be verified for illegal op: op=1111111 -> illegal_op=1 for one cycle in DECODE, next state 0, no write strobes asserted.
REQ-036 SHALL be verified for mid-op reset: rst_n=0 during MEMWRITE with mem_ready=0 -> mem_write=0 in that cycle, state_o=0 after the edge.
